timer_regs: RTL and testbench



---
 rtl/timer_regs_pkg.sv | 41 ++++
 rtl/timer_regs_if.sv | 20 ++
 rtl/timer_backlog.sv | 44 ++++
 rtl/timer_regs.sv | 135 +++++++++++++
 tb/tb_timer_regs.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_regs_pkg.sv
// Shared constants and types for the DMG timer register block.
// Register offsets, TAC fields, tap selects and FSM states.
package timer_regs_pkg;

  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  localparam int TAC_W      = 3;
  localparam int TAC_EN_BIT = 2;

  localparam logic [1:0] TAP_BIT9 = 2'b00;
  localparam logic [1:0] TAP_BIT3 = 2'b01;
  localparam logic [1:0] TAP_BIT5 = 2'b10;
  localparam logic [1:0] TAP_BIT7 = 2'b11;

  localparam logic [15:0] SYS_STEP   = 16'd4;
  localparam logic [7:0]  IRQ_VECTOR = 8'h50;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_OVF = 1'b1
  } state_t;

  function automatic logic tapBit(
    input logic [15:0] cnt,
    input logic [1:0]  sel
  );
    logic b;
    b = 1'b0;
    unique case (sel)
      TAP_BIT9: b = cnt[9];
      TAP_BIT3: b = cnt[3];
      TAP_BIT5: b = cnt[5];
      TAP_BIT7: b = cnt[7];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/timer_regs_if.sv
// CPU-side bus of the timer block: retire strobe with cycle count,
// register write strobe/select/data and combinational read data.
interface timer_regs_if;
  logic       iTick;
  logic [2:0] iMCycles;
  logic       iWe;
  logic [1:0] iAddr;
  logic [7:0] iData;
  logic [7:0] oData;

  modport master (
    output iTick, iMCycles, iWe, iAddr, iData,
    input  oData
  );

  modport slave (
    input  iTick, iMCycles, iWe, iAddr, iData,
    output oData
  );
endinterface

// File: rtl/timer_backlog.sv
// Pending M-cycle backlog: accumulates retired cycle counts and
// drains one per clock (oStep); saturates and flags sticky oOverrun.
module timer_backlog #(
  parameter int PENDING_W = 4
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iTick,
  input  logic [2:0] iMCycles,
  output logic       oStep,
  output logic       oOverrun
);

  localparam int SW = PENDING_W + 1;
  localparam logic [SW-1:0] MAXV =
    {1'b0, {PENDING_W{1'b1}}};

  logic [PENDING_W-1:0] rPending;
  logic [SW-1:0]        sum;
  logic [SW-1:0]        add;
  logic                 sat;

  always_comb begin
    oStep = (rPending != '0);
    add   = iTick ? SW'(iMCycles) : '0;
    sum   = {1'b0, rPending} + add - SW'(oStep);
    sat   = (sum > MAXV);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      rPending <= '0;
      oOverrun <= 1'b0;
    end else begin
      if (sat) begin
        rPending <= MAXV[PENDING_W-1:0];
        oOverrun <= 1'b1;
      end else begin
        rPending <= sum[PENDING_W-1:0];
      end
    end
  end

endmodule

// File: rtl/timer_regs.sv
// DMG timer registers (DIV/TIMA/TMA/TAC) driven by retired M-cycles;
// ports: iClock, iReset, bus (slave), oInterrupt0x50, oOverrun, oDiv.
module timer_regs
  import timer_regs_pkg::*;
#(
  parameter int         PENDING_W = 4,
  parameter logic [7:0] TMA_RESET = 8'h00
) (
  input  logic         iClock,
  input  logic         iReset,
  timer_regs_if.slave  bus,
  output logic         oInterrupt0x50,
  output logic         oOverrun,
  output logic [7:0]   oDiv
);

  logic [15:0]      rSysCnt;
  logic [7:0]       rTima;
  logic [7:0]       rTma;
  logic [TAC_W-1:0] rTac;
  logic             rTinD;
  logic             rIrq;
  state_t           state;
  state_t           stateNext;
  logic [7:0]       timaNext;
  logic             irqNext;

  logic step;
  logic tin;
  logic incr;
  logic wrDiv;
  logic wrTima;
  logic wrTma;
  logic wrTac;

  timer_backlog #(
    .PENDING_W (PENDING_W)
  ) uBacklog (
    .iClock   (iClock),
    .iReset   (iReset),
    .iTick    (bus.iTick),
    .iMCycles (bus.iMCycles),
    .oStep    (step),
    .oOverrun (oOverrun)
  );

  always_comb begin
    wrDiv  = bus.iWe && (bus.iAddr == REG_DIV);
    wrTima = bus.iWe && (bus.iAddr == REG_TIMA);
    wrTma  = bus.iWe && (bus.iAddr == REG_TMA);
    wrTac  = bus.iWe && (bus.iAddr == REG_TAC);
  end

  // Falling edge of the gated tap; any cause of the edge counts.
  always_comb begin
    tin  = rTac[TAC_EN_BIT] &
           tapBit(rSysCnt, rTac[1:0]);
    incr = rTinD & ~tin;
  end

  always_comb begin
    stateNext = state;
    timaNext  = rTima;
    irqNext   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (wrTima) begin
          timaNext = bus.iData;
        end else if (incr) begin
          if (rTima == 8'hFF) begin
            timaNext  = 8'h00;
            stateNext = ST_OVF;
          end else begin
            timaNext = rTima + 8'd1;
          end
        end
      end
      ST_OVF: begin
        if (wrTima) begin
          timaNext  = bus.iData;
          stateNext = ST_RUN;
        end else if (step) begin
          // A same-clock TMA write is what gets reloaded.
          timaNext  = wrTma ? bus.iData : rTma;
          irqNext   = 1'b1;
          stateNext = ST_RUN;
        end else if (incr) begin
          timaNext = rTima + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state   <= ST_RUN;
      rSysCnt <= 16'h0000;
      rTima   <= 8'h00;
      rTma    <= TMA_RESET;
      rTac    <= '0;
      rTinD   <= 1'b0;
      rIrq    <= 1'b0;
    end else begin
      state <= stateNext;
      rTima <= timaNext;
      rIrq  <= irqNext;
      rTinD <= tin;
      if (wrDiv) begin
        rSysCnt <= 16'h0000;
      end else if (step) begin
        rSysCnt <= rSysCnt + SYS_STEP;
      end
      if (wrTma) begin
        rTma <= bus.iData;
      end
      if (wrTac) begin
        rTac <= bus.iData[TAC_W-1:0];
      end
    end
  end

  always_comb begin
    bus.oData = 8'h00;
    unique case (1'b1)
      bus.iAddr == REG_DIV:  bus.oData = rSysCnt[15:8];
      bus.iAddr == REG_TIMA: bus.oData = rTima;
      bus.iAddr == REG_TMA:  bus.oData = rTma;
      bus.iAddr == REG_TAC:  bus.oData = {5'b11111, rTac};
    endcase
  end

  assign oDiv           = rSysCnt[15:8];
  assign oInterrupt0x50 = rIrq;

endmodule

// File: tb/tb_timer_regs.sv
// Randomized + directed scoreboard bench for timer_regs.
// A cycle-level reference model predicts outputs per clock.
module tb_timer_regs;

  localparam logic [7:0] TMA_R = 8'h3C;
  localparam int PMAX = 15;

  logic iClock = 1'b0;
  logic iReset = 1'b1;
  logic oInterrupt0x50;
  logic oOverrun;
  logic [7:0] oDiv;

  timer_regs_if bus();

  timer_regs #(
    .PENDING_W (4),
    .TMA_RESET (TMA_R)
  ) dut (
    .iClock         (iClock),
    .iReset         (iReset),
    .bus            (bus),
    .oInterrupt0x50 (oInterrupt0x50),
    .oOverrun       (oOverrun),
    .oDiv           (oDiv)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic [7:0] div;
    logic [7:0] data;
    logic       irq;
    logic       ovr;
    int         addr;
  } exp_t;

  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  int mSys, mPend, mTima, mTma, mTac;
  bit mOvf, mTinPrev, mIrq, mOvr;
  int taps[4] = '{9, 3, 5, 7};

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, req);
    end
  endtask

  function automatic int readModel(input int addr);
    case (addr)
      0: return (mSys >> 8) & 255;
      1: return mTima;
      2: return mTma;
      default: return 8'hF8 | mTac;
    endcase
  endfunction

  task automatic modelReset();
    mSys = 0; mPend = 0; mTima = 0; mTma = TMA_R; mTac = 0;
    mOvf = 0; mTinPrev = 0; mIrq = 0; mOvr = 0;
  endtask

  task automatic advance(input bit rst, input bit tk,
                         input int mc, input bit we,
                         input int addr, input int data);
    bit step, tinNow, fall, wD, wT, wM, wC;
    if (rst) begin
      modelReset();
      return;
    end
    step   = (mPend > 0);
    tinNow = ((mTac >> 2) & 1) && ((mSys >> taps[mTac & 3]) & 1);
    fall   = mTinPrev && !tinNow;
    wD = we && addr == 0;
    wT = we && addr == 1;
    wM = we && addr == 2;
    wC = we && addr == 3;
    mIrq = 0;
    if (wT) begin
      mTima = data;
      mOvf  = 0;
    end else if (mOvf && step) begin
      mTima = wM ? data : mTma;
      mIrq  = 1;
      mOvf  = 0;
    end else if (fall) begin
      if (mTima == 255) begin
        mTima = 0;
        mOvf  = 1;
      end else begin
        mTima = mTima + 1;
      end
    end
    mTinPrev = tinNow;
    if (wD) mSys = 0;
    else if (step) mSys = (mSys + 4) % 65536;
    if (wM) mTma = data;
    if (wC) mTac = data & 7;
    mPend = mPend + (tk ? mc : 0) - (step ? 1 : 0);
    if (mPend > PMAX) begin
      mPend = PMAX;
      mOvr  = 1;
    end
  endtask

  task automatic cyc(input bit rst, input bit tk, input int mc,
                     input bit we, input int addr, input int data);
    exp_t e;
    @(posedge iClock);
    #1;
    iReset       = rst;
    bus.iTick    = tk;
    bus.iMCycles = 3'(mc);
    bus.iWe      = we;
    bus.iAddr    = 2'(addr);
    bus.iData    = 8'(data);
    e.div  = 8'((mSys >> 8) & 255);
    e.data = 8'(readModel(addr));
    e.irq  = mIrq;
    e.ovr  = mOvr;
    e.addr = addr;
    sbq.push_back(e);
    advance(rst, tk, mc, we, addr, data);
  endtask

  task automatic idle(input int addr);
    cyc(0, 0, 0, 0, addr, 0);
  endtask

  task automatic wr(input int addr, input int data);
    cyc(0, 0, 0, 1, addr, data);
  endtask

  // Step one M-cycle at a time until the model reaches OVF.
  task automatic toOvf();
    bit done;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      cyc(0, 1, 1, 0, 1, 0);
      idle(1);
      idle(1);
      if (mOvf) done = 1;
    end
    if (!done) begin
      errors++;
      $display("FAIL ovf_reach: got no overflow expected one");
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge iClock);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("oDiv", oDiv, e.div);
        chk($sformatf("oData[a%0d]", e.addr), bus.oData, e.data);
        chk("oInterrupt0x50", 8'(oInterrupt0x50), 8'(e.irq));
        chk("oOverrun", 8'(oOverrun), 8'(e.ovr));
      end
    end
  end

  initial begin : stim
    bit rst, tk, we;
    bit hit;
    bus.iTick = 0; bus.iMCycles = 0; bus.iWe = 0;
    bus.iAddr = 0; bus.iData = 0;
    modelReset();
    cyc(1, 0, 0, 0, 2, 0);
    cyc(1, 0, 0, 0, 3, 0);

    wr(3, 5);
    cyc(0, 1, 4, 0, 1, 0);
    repeat (8) idle(1);
    idle(0);

    wr(2, 8'hAB);
    wr(1, 8'hFF);
    cyc(0, 1, 7, 0, 1, 0);
    repeat (14) idle(1);

    wr(1, 8'hFF);
    toOvf();
    wr(1, 8'h10);
    repeat (6) idle(1);

    wr(3, 4);
    wr(0, 0);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      if ((mSys >> 9) & 1) hit = 1;
    end
    idle(1);
    wr(0, 0);
    repeat (3) idle(1);
    idle(0);

    cyc(0, 1, 7, 0, 1, 0);
    cyc(0, 1, 7, 0, 1, 0);
    cyc(0, 1, 7, 0, 1, 0);
    repeat (20) idle(1);

    wr(3, 5);
    wr(1, 8'hFF);
    toOvf();
    cyc(0, 1, 5, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    repeat (8) idle(1);
    idle(2);
    idle(3);

    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      tk  = ($urandom_range(0, 4) == 0);
      we  = ($urandom_range(0, 7) == 0);
      cyc(rst, tk, $urandom_range(0, 7), we,
          $urandom_range(0, 3), $urandom_range(0, 255));
    end
    idle(1);

    @(negedge iClock);
    @(negedge iClock);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
